// File: rtl/pattern_detector_if.sv
// Bundles the programming, control, signal and status lines of the pattern detector.
interface pattern_detector_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 16
) ();
    localparam int unsigned TW = $clog2(N + 1);

    logic             prgm_en;
    logic             prgm;
    logic             mask;
    logic             arm;
    logic             disarm;
    logic             oneshot;
    logic [TW-1:0]    tol;
    logic             sig_valid;
    logic             sig;
    logic             hit;
    logic             armed;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    // Controller side: drives programming/control/signal, observes status.
    modport master (
        output prgm_en, prgm, mask, arm, disarm, oneshot, tol, sig_valid, sig,
        input  hit, armed, done, match_cnt
    );

    // Detector side.
    modport slave (
        input  prgm_en, prgm, mask, arm, disarm, oneshot, tol, sig_valid, sig,
        output hit, armed, done, match_cnt
    );
endinterface

// File: rtl/pattern_detector.sv
// Serial pattern detector: a programmable N-bit pattern with per-bit care mask is
// compared against the last N accepted signal bits, allowing up to tol cared mismatches.
module pattern_detector #(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              clr,
    pattern_detector_if.slave bus
);
    localparam int unsigned TW = $clog2(N + 1);
    localparam logic [TW-1:0] FillMax = TW'(N);

    typedef enum logic [1:0] {StIdle, StProgram, StArmed, StDone} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     preg_q, mreg_q, sreg_q;
    logic [TW-1:0]    fill_q;
    logic [TW-1:0]    fill_inc;
    logic             eval_q;
    logic             oneshot_q;
    logic             hit_q;
    logic [CNT_W-1:0] cnt_q;

    logic             prgm_shift;
    logic             sig_accept;
    logic             enter_armed;
    logic [N-1:0]     diff;
    logic [TW-1:0]    mism;
    logic             match;
    logic             do_hit;

    // Qualifiers for shifting, accepting and evaluating this cycle.
    always_comb begin
        prgm_shift  = (state_q == StIdle || state_q == StProgram) && bus.prgm_en;
        sig_accept  = (state_q == StArmed) && bus.sig_valid;
        enter_armed = (state_d == StArmed) && (state_q != StArmed);
        fill_inc    = (fill_q == FillMax) ? fill_q : fill_q + TW'(1);
        diff        = (sreg_q ^ preg_q) & mreg_q;
        mism        = '0;
        for (int i = 0; i < int'(N); i++) begin
            mism = mism + TW'(diff[i]);
        end
        // Evaluation is only meaningful while still armed; disarm cancels it.
        match  = eval_q && (state_q == StArmed) && (mism <= bus.tol);
        do_hit = match && !bus.disarm;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.prgm_en) begin
                    state_d = StProgram;
                end else if (bus.arm) begin
                    state_d = StArmed;
                end
            end
            StProgram: begin
                if (!bus.prgm_en) begin
                    state_d = StIdle;
                end
            end
            StArmed: begin
                if (bus.disarm) begin
                    state_d = StIdle;
                end else if (do_hit && oneshot_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.disarm) begin
                    state_d = StIdle;
                end else if (bus.arm) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.armed     = (state_q == StArmed);
        bus.done      = (state_q == StDone);
        bus.hit       = hit_q;
        bus.match_cnt = cnt_q;
    end

    // Pattern/mask shift registers, loaded serially oldest-first.
    always_ff @(posedge clk) begin
        if (clr) begin
            preg_q <= '0;
            mreg_q <= '1;
        end else if (prgm_shift) begin
            preg_q <= {preg_q[N-2:0], bus.prgm};
            mreg_q <= {mreg_q[N-2:0], bus.mask};
        end
    end

    // Signal window, fill tracking and evaluation request.
    always_ff @(posedge clk) begin
        if (clr) begin
            sreg_q <= '0;
            fill_q <= '0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= sig_accept && (fill_inc == FillMax);
            if (sig_accept) begin
                sreg_q <= {sreg_q[N-2:0], bus.sig};
            end
            if (enter_armed) begin
                fill_q <= '0;
            end else if (sig_accept) begin
                fill_q <= fill_inc;
            end
        end
    end

    // Hit pulse, saturating match counter and oneshot latch.
    always_ff @(posedge clk) begin
        if (clr) begin
            hit_q     <= 1'b0;
            cnt_q     <= '0;
            oneshot_q <= 1'b0;
        end else begin
            hit_q <= do_hit;
            if (do_hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (enter_armed) begin
                oneshot_q <= bus.oneshot;
            end
        end
    end
endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector (N=8, CNT_W=4) with a queue-based reference model.
module tb_pattern_detector;
    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_PROG = 1, M_ARMED = 2, M_DONE = 3;

    logic clk;
    logic clr;
    int   checks;
    int   errors;
    int   hit_seen;

    pattern_detector_if #(.N(N), .CNT_W(CNT_W)) bus ();

    pattern_detector #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: histories of programmed/mask/signal bits, oldest at front.
    bit pq[$];
    bit mq[$];
    bit sq[$];
    int m_mode, m_fill, m_cnt;
    bit m_pend, m_hit, m_one;

    function automatic void model_reset();
        pq = {}; mq = {}; sq = {};
        for (int i = 0; i < N; i++) begin
            pq.push_back(1'b0);
            mq.push_back(1'b1);
            sq.push_back(1'b0);
        end
        m_mode = M_IDLE; m_fill = 0; m_cnt = 0;
        m_pend = 0; m_hit = 0; m_one = 0;
    endfunction

    function automatic void model_step();
        int mm;
        int nmode;
        bit acc;
        bit mt;
        if (clr) begin
            model_reset();
            return;
        end
        mt = 0;
        if (m_mode == M_ARMED && m_pend) begin
            mm = 0;
            for (int i = 0; i < N; i++) if (mq[i] && (pq[i] != sq[i])) mm++;
            mt = (mm <= int'(bus.tol));
        end
        m_hit = mt && !bus.disarm;
        acc   = (m_mode == M_ARMED) && bus.sig_valid;
        nmode = m_mode;
        case (m_mode)
            M_IDLE:  if (bus.prgm_en) nmode = M_PROG; else if (bus.arm) nmode = M_ARMED;
            M_PROG:  if (!bus.prgm_en) nmode = M_IDLE;
            M_ARMED: if (bus.disarm) nmode = M_IDLE; else if (m_hit && m_one) nmode = M_DONE;
            default: if (bus.disarm) nmode = M_IDLE; else if (bus.arm) nmode = M_ARMED;
        endcase
        if ((m_mode == M_IDLE || m_mode == M_PROG) && bus.prgm_en) begin
            pq.push_back(bus.prgm); void'(pq.pop_front());
            mq.push_back(bus.mask); void'(mq.pop_front());
        end
        m_pend = 0;
        if (acc) begin
            sq.push_back(bus.sig); void'(sq.pop_front());
            if (m_fill < N) m_fill++;
            m_pend = (m_fill == N);
        end
        if (nmode == M_ARMED && m_mode != M_ARMED) begin
            m_fill = 0;
            m_one  = bus.oneshot;
        end
        if (m_hit && m_cnt < CMAX) m_cnt++;
        m_mode = nmode;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (bus.hit === 1'b1) hit_seen++;
    endtask

    task automatic idle_inputs();
        bus.prgm_en = 0; bus.prgm = 0; bus.mask = 0; bus.arm = 0; bus.disarm = 0;
        bus.oneshot = 0; bus.sig_valid = 0; bus.sig = 0;
    endtask

    task automatic do_clr();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
    endtask

    // First programmed bit is pat[7], matched against the oldest signal bit.
    task automatic program_pattern(input logic [7:0] pat, input logic [7:0] msk);
        for (int i = N - 1; i >= 0; i--) begin
            bus.prgm_en = 1; bus.prgm = pat[i]; bus.mask = msk[i];
            tick();
        end
        bus.prgm_en = 0;
        tick();
    endtask

    task automatic arm_det(input bit os);
        bus.arm = 1; bus.oneshot = os;
        tick();
        bus.arm = 0; bus.oneshot = 0;
    endtask

    task automatic send_bit(input bit b);
        bus.sig_valid = 1; bus.sig = b;
        tick();
        bus.sig_valid = 0;
    endtask

    task automatic test_reset();
        clr = 1;
        bus.prgm_en = 1; bus.arm = 1; bus.sig_valid = 1; bus.sig = 1;
        tick();
        clr = 0;
        idle_inputs();
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b expected 0", bus.hit); end
        checks++;
        if (bus.armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %0b expected 0", bus.armed); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        checks++;
        if (bus.match_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.match_cnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] p;
        p = 8'b10110010;
        do_clr();
        program_pattern(p, 8'hFF);
        bus.tol = 0;
        arm_det(0);
        hit_seen = 0;
        for (int i = N - 1; i >= 0; i--) send_bit(p[i]);
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL basic_early: got %0b expected 0", bus.hit); end
        tick();
        checks++;
        if (bus.hit !== 1'b1) begin errors++; $display("FAIL basic_latency: got %0b expected 1", bus.hit); end
        tick();
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0b expected 0", bus.hit); end
        checks++;
        if (hit_seen != 1) begin errors++; $display("FAIL basic_hits: got %0d expected 1", hit_seen); end
        checks++;
        if (bus.match_cnt !== 4'd1) begin
            errors++; $display("FAIL basic_cnt: got %0d expected 1", bus.match_cnt);
        end
        checks++;
        if (bus.armed !== 1'b1) begin errors++; $display("FAIL basic_armed: got %0b expected 1", bus.armed); end
    endtask

    task automatic test_gaps();
        logic [7:0] p;
        p = 8'b10110010;
        do_clr();
        program_pattern(p, 8'hFF);
        bus.tol = 0;
        arm_det(0);
        hit_seen = 0;
        for (int i = N - 1; i >= 1; i--) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.sig = $urandom_range(0, 1);
                tick();
            end
            send_bit(p[i]);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (hit_seen != 0) begin errors++; $display("FAIL gaps_hits: got %0d expected 0", hit_seen); end
        checks++;
        if (bus.match_cnt !== 4'd0) begin
            errors++; $display("FAIL gaps_cnt: got %0d expected 0", bus.match_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [9:0] s;
        s = 10'b1010101010;
        do_clr();
        program_pattern(8'b10101010, 8'hFF);
        bus.tol = 0;
        arm_det(0);
        hit_seen = 0;
        for (int i = 9; i >= 0; i--) send_bit(s[i]);
        tick();
        tick();
        checks++;
        if (hit_seen != 2) begin errors++; $display("FAIL overlap_hits: got %0d expected 2", hit_seen); end
        checks++;
        if (bus.match_cnt !== 4'd2) begin
            errors++; $display("FAIL overlap_cnt: got %0d expected 2", bus.match_cnt);
        end
    endtask

    task automatic test_tolerance();
        logic [7:0] s;
        s = 8'b11010011;
        for (int t = 1; t >= 0; t--) begin
            do_clr();
            program_pattern(8'b11110000, 8'b11111100);
            bus.tol = 4'(t);
            arm_det(0);
            hit_seen = 0;
            for (int i = N - 1; i >= 0; i--) send_bit(s[i]);
            tick();
            tick();
            checks++;
            if (hit_seen != t) begin
                errors++; $display("FAIL tol%0d_hits: got %0d expected %0d", t, hit_seen, t);
            end
            checks++;
            if (int'(bus.match_cnt) != t) begin
                errors++; $display("FAIL tol%0d_cnt: got %0d expected %0d", t, bus.match_cnt, t);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] p;
        p = 8'b10110010;
        do_clr();
        program_pattern(p, 8'hFF);
        bus.tol = 0;
        arm_det(1);
        hit_seen = 0;
        for (int r = 0; r < 2; r++) for (int i = N - 1; i >= 0; i--) send_bit(p[i]);
        tick();
        tick();
        checks++;
        if (hit_seen != 1) begin errors++; $display("FAIL oneshot_hits: got %0d expected 1", hit_seen); end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL oneshot_done: got %0b expected 1", bus.done); end
        checks++;
        if (bus.armed !== 1'b0) begin
            errors++; $display("FAIL oneshot_armed: got %0b expected 0", bus.armed);
        end
        checks++;
        if (bus.match_cnt !== 4'd1) begin
            errors++; $display("FAIL oneshot_cnt: got %0d expected 1", bus.match_cnt);
        end
        arm_det(0);
        checks++;
        if (bus.armed !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rearm: got armed=%0b done=%0b expected armed=1 done=0", bus.armed, bus.done);
        end
    endtask

    task automatic test_disarm();
        logic [7:0] p;
        p = 8'b10110010;
        do_clr();
        program_pattern(p, 8'hFF);
        bus.tol = 0;
        arm_det(0);
        hit_seen = 0;
        for (int i = N - 1; i >= 0; i--) send_bit(p[i]);
        bus.disarm = 1;
        tick();
        bus.disarm = 0;
        tick();
        checks++;
        if (hit_seen != 0) begin errors++; $display("FAIL disarm_hits: got %0d expected 0", hit_seen); end
        checks++;
        if (bus.match_cnt !== 4'd0) begin
            errors++; $display("FAIL disarm_cnt: got %0d expected 0", bus.match_cnt);
        end
        checks++;
        if (bus.armed !== 1'b0) begin errors++; $display("FAIL disarm_armed: got %0b expected 0", bus.armed); end
    endtask

    task automatic test_saturation();
        do_clr();
        program_pattern(8'($urandom), 8'h00);
        bus.tol = 0;
        arm_det(0);
        hit_seen = 0;
        for (int i = 0; i < 24; i++) send_bit(1'($urandom));
        tick();
        tick();
        checks++;
        if (hit_seen != 17) begin errors++; $display("FAIL sat_hits: got %0d expected 17", hit_seen); end
        checks++;
        if (bus.match_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_cnt: got %0d expected 15", bus.match_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            bus.sig_valid = 1; bus.sig = 1'($urandom);
            tick();
        end
        clr = 1;
        tick();
        clr = 0;
        checks++;
        if (bus.hit !== 1'b0 || bus.armed !== 1'b0 || bus.done !== 1'b0 || bus.match_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_mid: got hit=%0b armed=%0b done=%0b cnt=%0d expected all 0",
                     bus.hit, bus.armed, bus.done, bus.match_cnt);
        end
        tick();
        bus.sig_valid = 0;
        checks++;
        if (bus.armed !== 1'b0 || bus.hit !== 1'b0) begin
            errors++; $display("FAIL clr_idle: got armed=%0b hit=%0b expected 0 0", bus.armed, bus.hit);
        end
    endtask

    task automatic test_random();
        do_clr();
        for (int c = 0; c < 4000; c++) begin
            clr           = ($urandom_range(0, 299) == 0);
            bus.prgm_en   = ($urandom_range(0, 5) == 0);
            bus.prgm      = 1'($urandom);
            bus.mask      = ($urandom_range(0, 9) < 6);
            bus.arm       = ($urandom_range(0, 7) == 0);
            bus.disarm    = ($urandom_range(0, 39) == 0);
            bus.oneshot   = 1'($urandom);
            bus.sig_valid = ($urandom_range(0, 2) != 0);
            bus.sig       = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.tol = 4'($urandom_range(0, N));
            tick();
            checks++;
            if (bus.hit !== m_hit) begin
                errors++; $display("FAIL rnd_hit @%0d: got %0b expected %0b", c, bus.hit, m_hit);
            end
            checks++;
            if (bus.armed !== (m_mode == M_ARMED)) begin
                errors++; $display("FAIL rnd_armed @%0d: got %0b expected %0b", c, bus.armed,
                                   m_mode == M_ARMED);
            end
            checks++;
            if (bus.done !== (m_mode == M_DONE)) begin
                errors++; $display("FAIL rnd_done @%0d: got %0b expected %0b", c, bus.done,
                                   m_mode == M_DONE);
            end
            checks++;
            if (int'(bus.match_cnt) != m_cnt) begin
                errors++; $display("FAIL rnd_cnt @%0d: got %0d expected %0d", c, bus.match_cnt, m_cnt);
            end
        end
        clr = 0;
        idle_inputs();
    endtask

    initial begin
        clk = 0;
        clr = 1;
        checks = 0;
        errors = 0;
        hit_seen = 0;
        idle_inputs();
        bus.tol = 0;
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_overlap();
        test_tolerance();
        test_oneshot();
        test_disarm();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
